// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter-side bundle for uart_tx_scheduler.
// master = packet logic driving requests; slave = the scheduler itself.
interface uart_tx_scheduler_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   REQ;
    logic [8*N_REQ-1:0] DATA_REQ;
    logic               ABORT;
    logic [N_REQ-1:0]   ACK;
    logic [N_REQ-1:0]   DONE;
    logic               IDLE_UART;
    logic [7:0]         data_out;
    logic               BUSY;
    logic [ID_W-1:0]    GRANT_ID;

    modport master (
        output REQ, DATA_REQ, ABORT,
        input  ACK, DONE, IDLE_UART, data_out, BUSY, GRANT_ID
    );

    modport slave (
        input  REQ, DATA_REQ, ABORT,
        output ACK, DONE, IDLE_UART, data_out, BUSY, GRANT_ID
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ requesters:
// grant, hold the byte for one frame with IDLE_UART low, then a guard gap.
module uart_tx_scheduler #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned FRAME_CYCLES = 12,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic               UART_CLK,
    input  logic               RESET,
    uart_tx_scheduler_if.slave bus
);
    localparam int unsigned ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [ID_W-1:0]    ptr, ptr_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               idle_q, idle_d;
    logic [7:0]         data_q, data_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    gid_q, gid_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [7:0]         win_byte;
    logic [ID_W-1:0]    win_next;

    // Rotating priority search: first set REQ bit at or above ptr, wrapping.
    always_comb begin : arb
        int unsigned idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!win_found && bus.REQ[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign win_byte = bus.DATA_REQ[32'(win_id) * 8 +: 8];
    assign win_next = ((32'(win_id) + 1) >= N_REQ) ? '0 : ID_W'(32'(win_id) + 1);

    // Next-state and next-output logic; ACK/DONE default to zero so they pulse.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        idle_d  = idle_q;
        data_d  = data_q;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        gid_d   = gid_q;

        case (state)
            ST_ARB: begin
                idle_d = 1'b1;
                if (win_found) begin
                    data_d         = win_byte;
                    ack_d[win_id]  = 1'b1;
                    gid_d          = win_id;
                    busy_d         = 1'b1;
                    idle_d         = 1'b0;
                    cnt_d          = '0;
                    ptr_d          = win_next;
                    state_d        = ST_SEND;
                end
            end

            ST_SEND: begin
                // Abort outranks normal completion, even on the final cycle.
                if (bus.ABORT) begin
                    idle_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt == FRAME_LAST) begin
                    idle_d        = 1'b1;
                    done_d[gid_q] = 1'b1;
                    busy_d        = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_GAP;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            ST_GAP: begin
                idle_d = 1'b1;
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ARB;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            default: begin
                idle_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_ARB;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge UART_CLK) begin
        if (RESET) begin
            state  <= ST_ARB;
            ptr    <= '0;
            cnt    <= '0;
            idle_q <= 1'b1;
            data_q <= '0;
            ack_q  <= '0;
            done_q <= '0;
            busy_q <= 1'b0;
            gid_q  <= '0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            cnt    <= cnt_d;
            idle_q <= idle_d;
            data_q <= data_d;
            ack_q  <= ack_d;
            done_q <= done_d;
            busy_q <= busy_d;
            gid_q  <= gid_d;
        end
    end

    assign bus.ACK       = ack_q;
    assign bus.DONE      = done_q;
    assign bus.IDLE_UART = idle_q;
    assign bus.data_out  = data_q;
    assign bus.BUSY      = busy_q;
    assign bus.GRANT_ID  = gid_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed + randomized bench for uart_tx_scheduler against a timestamp-based
// transaction model (grant edge, frame end edge, earliest next arbitration edge).
module tb_uart_tx_scheduler;
    localparam int unsigned N     = 4;
    localparam int unsigned FRAME = 12;
    localparam int unsigned GAP   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_REQ(N)) bus ();

    uart_tx_scheduler #(
        .N_REQ       (N),
        .FRAME_CYCLES(FRAME),
        .GAP_CYCLES  (GAP)
    ) dut (
        .UART_CLK(clk),
        .RESET   (rst),
        .bus     (bus.slave)
    );

    int unsigned checks = 0;
    int unsigned fails  = 0;
    int unsigned edge_n = 0;

    // Reference model: expected outputs plus frame timestamps.
    logic [N-1:0] m_ack  = '0;
    logic [N-1:0] m_done = '0;
    logic         m_idle = 1'b1;
    logic [7:0]   m_data = '0;
    logic         m_busy = 1'b0;
    logic [1:0]   m_gid  = '0;
    int unsigned  m_ptr  = 0;
    bit           m_inframe = 1'b0;
    int unsigned  m_g      = 0;
    int unsigned  m_arb_ok = 0;

    int unsigned ack_edges[$];
    int unsigned ack_ids[$];
    int unsigned done_edges[$];
    int unsigned done_vals[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge();
        bit found;
        int unsigned k;
        m_ack  = '0;
        m_done = '0;
        if (rst) begin
            m_idle = 1'b1; m_data = '0; m_busy = 1'b0; m_gid = '0;
            m_ptr = 0; m_inframe = 1'b0; m_arb_ok = edge_n + 1;
        end else if (m_inframe) begin
            if (bus.ABORT) begin
                m_inframe = 1'b0; m_idle = 1'b1; m_busy = 1'b0;
                m_arb_ok  = edge_n + GAP + 1;
            end else if (edge_n == m_g + FRAME) begin
                m_done[m_gid] = 1'b1;
                m_inframe = 1'b0; m_idle = 1'b1; m_busy = 1'b0;
                m_arb_ok  = edge_n + GAP + 1;
            end
        end else if (edge_n >= m_arb_ok && bus.REQ != '0) begin
            found = 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (!found && bus.REQ[k]) begin
                    found     = 1'b1;
                    m_ack[k]  = 1'b1;
                    m_data    = bus.DATA_REQ[8*k +: 8];
                    m_gid     = 2'(k);
                    m_busy    = 1'b1;
                    m_idle    = 1'b0;
                    m_ptr     = (k + 1) % N;
                    m_inframe = 1'b1;
                    m_g       = edge_n;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check("ACK",       32'(bus.ACK),       32'(m_ack));
        check("DONE",      32'(bus.DONE),      32'(m_done));
        check("IDLE_UART", 32'(bus.IDLE_UART), 32'(m_idle));
        check("data_out",  32'(bus.data_out),  32'(m_data));
        check("BUSY",      32'(bus.BUSY),      32'(m_busy));
        check("GRANT_ID",  32'(bus.GRANT_ID),  32'(m_gid));
        if (bus.ACK != '0) begin
            ack_edges.push_back(edge_n);
            ack_ids.push_back(32'(bus.GRANT_ID));
        end
        if (bus.DONE != '0) begin
            done_edges.push_back(edge_n);
            done_vals.push_back(32'(bus.DONE));
        end
    endtask

    task automatic clear_logs();
        ack_edges.delete(); ack_ids.delete();
        done_edges.delete(); done_vals.delete();
    endtask

    task automatic wait_acks(input int unsigned n);
        int unsigned budget;
        budget = 0;
        while (ack_edges.size() < n && budget < 200) begin
            tick();
            budget++;
        end
        check("ack_wait", 32'(ack_edges.size() >= n), 32'd1);
    endtask

    initial begin
        int unsigned low_cnt;
        int unsigned abort_edge;

        rst = 1'b1;
        bus.REQ = '0;
        bus.DATA_REQ = '0;
        bus.ABORT = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Single requester frame shape.
        clear_logs();
        bus.REQ = 4'b0001;
        bus.DATA_REQ[7:0] = 8'hA5;
        wait_acks(1);
        bus.REQ = '0;
        low_cnt = (bus.IDLE_UART == 1'b0) ? 1 : 0;
        repeat (16) begin
            tick();
            if (bus.IDLE_UART == 1'b0) low_cnt++;
        end
        check("t1_idle_low_cycles", low_cnt, FRAME);
        check("t1_done_count", done_edges.size(), 1);
        if (done_edges.size() == 1) begin
            check("t1_done_latency", done_edges[0] - ack_edges[0], FRAME);
            check("t1_done_val", done_vals[0], 32'h1);
        end

        // All requesters: rotation and spacing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
        bus.REQ = 4'b1111;
        bus.DATA_REQ = 32'h44332211;
        wait_acks(5);
        if (ack_ids.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t2_grant_seq", ack_ids[i], i % 4);
                if (i > 0) check("t2_grant_period", ack_edges[i] - ack_edges[i-1], FRAME + GAP + 1);
            end
        end

        // Sparse requests skip from ptr=1 to 2, then wrap to 0; REQ[2] drops after ACK.
        clear_logs();
        bus.REQ = 4'b0101;
        wait_acks(1);
        bus.REQ = 4'b0001;
        wait_acks(2);
        bus.REQ = '0;
        if (ack_ids.size() == 2) begin
            check("t3_first", ack_ids[0], 2);
            check("t3_second", ack_ids[1], 0);
        end
        check("t3_done_cnt", done_vals.size(), 2);
        if (done_vals.size() >= 2) check("t3_done_req2", done_vals[1], 32'h4);

        // Byte frozen during SEND.
        repeat (20) tick();
        clear_logs();
        bus.REQ = 4'b0001;
        bus.DATA_REQ[7:0] = 8'hA5;
        wait_acks(1);
        bus.REQ = '0;
        bus.DATA_REQ[7:0] = 8'h3C;
        repeat (11) begin
            tick();
            check("t4_data_frozen", 32'(bus.data_out), 32'hA5);
        end
        repeat (5) tick();

        // Abort mid-frame and on final cycle.
        clear_logs();
        bus.REQ = 4'b0010;
        bus.DATA_REQ[15:8] = 8'h5A;
        wait_acks(1);
        bus.REQ = 4'b0001;
        repeat (5) tick();
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        abort_edge = edge_n;
        check("t5_abort_idle", 32'(bus.IDLE_UART), 32'd1);
        wait_acks(2);
        bus.REQ = '0;
        if (ack_edges.size() == 2) begin
            check("t5_regrant_delay", ack_edges[1] - abort_edge, GAP + 1);
            check("t5_regrant_id", ack_ids[1], 0);
        end
        repeat (11) tick();
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        check("t5_abort_last_idle", 32'(bus.IDLE_UART), 32'd1);
        repeat (5) tick();
        check("t5_no_done", done_edges.size(), 0);

        // Reset mid-frame.
        clear_logs();
        bus.REQ = 4'b0100;
        wait_acks(1);
        bus.REQ = '0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        check("t6_idle", 32'(bus.IDLE_UART), 32'd1);
        check("t6_data", 32'(bus.data_out), 32'd0);
        check("t6_busy", 32'(bus.BUSY), 32'd0);
        check("t6_done", 32'(bus.DONE), 32'd0);
        rst = 1'b0;
        clear_logs();
        bus.REQ = 4'b1111;
        wait_acks(1);
        if (ack_ids.size() >= 1) check("t6_first_after_reset", ack_ids[0], 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(7) == 0) bus.REQ[b] = ~bus.REQ[b];
            end
            bus.DATA_REQ = $urandom;
            bus.ABORT = ($urandom_range(19) == 0);
            rst = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.REQ = '0;
        bus.ABORT = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
